// File: rtl/mptw_req_arbiter_if.sv
// Walk-transaction type and the requester/fetch-side bundle of the MPT walk arbiter.
package mpt_pkg;
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] mpt_addr;
    logic [7:0]  tag;
  } mptw_transaction_t;
endpackage

interface mptw_req_arbiter_if
  import mpt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
  logic              [NUM_REQ-1:0] req_valid_i;
  mptw_transaction_t [NUM_REQ-1:0] req_transaction_i;
  logic              [NUM_REQ-1:0] req_ready_o;
  logic                            mptw_valid_o;
  mptw_transaction_t               mptw_transaction_o;
  logic                            mptw_ready_i;
  logic              [IDX_W-1:0]   grant_id_o;

  modport slave (
    input  req_valid_i, req_transaction_i, mptw_ready_i,
    output req_ready_o, mptw_valid_o, mptw_transaction_o, grant_id_o
  );

  modport master (
    output req_valid_i, req_transaction_i, mptw_ready_i,
    input  req_ready_o, mptw_valid_o, mptw_transaction_o, grant_id_o
  );
endinterface

// File: rtl/mptw_req_arbiter.sv
// Round-robin arbiter feeding one registered MPT walk transaction to the fetch stage.
module mptw_req_arbiter
  import mpt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  output logic                busy_o,
  mptw_req_arbiter_if.slave   bus
);

  logic              r_out_valid;
  mptw_transaction_t r_out_txn;
  logic [IDX_W-1:0]  r_out_id;
  logic [IDX_W-1:0]  r_last_grant;

  logic               w_load_en;
  logic               w_found;
  logic               w_accept;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_ready;
  int unsigned        w_pos;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_pos   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pos = (32'(r_last_grant) + 32'd1 + i) % NUM_REQ;
      w_idx = IDX_W'(w_pos);
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_load_en = (~r_out_valid | bus.mptw_ready_i) & ~flush_i;
  assign w_accept  = w_load_en & w_found & ~rst_i;

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_txn    <= '0;
      r_out_id     <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_txn    <= bus.req_transaction_i[w_win];
      r_out_id     <= w_win;
      r_last_grant <= w_win;
    end else if (r_out_valid && bus.mptw_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o        = w_ready;
  assign bus.mptw_valid_o       = r_out_valid;
  assign bus.mptw_transaction_o = r_out_txn;
  assign bus.grant_id_o         = r_out_id;
  assign busy_o                 = ~rst_i & (r_out_valid | (|bus.req_valid_i));

endmodule

// File: tb/tb_mptw_req_arbiter.sv
// Randomized and directed checks of mptw_req_arbiter against a distance-based round-robin model.
module tb_mptw_req_arbiter;
  import mpt_pkg::*;

  localparam int N = 4;
  localparam int W = 2;

  logic clk;
  logic rst;
  logic flush;
  logic busy;

  mptw_req_arbiter_if #(.NUM_REQ(N), .IDX_W(W)) bus ();

  mptw_req_arbiter #(.NUM_REQ(N), .IDX_W(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .busy_o  (busy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit                m_valid;
  mptw_transaction_t m_txn;
  int                m_id;
  int                m_last;
  mptw_transaction_t sb[$];
  int                wait_cnt[N];
  logic [N-1:0]      obs_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_txn   = '0;
    m_id    = 0;
    m_last  = N - 1;
    sb.delete();
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
  endtask

  // Winner = valid requester at the smallest circular distance past the last grant.
  function automatic int pick(input logic [N-1:0] v);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        int d;
        d = (k - m_last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  function automatic mptw_transaction_t rand_txn();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[41:0];
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic fl);
    int           w;
    logic         load;
    logic [N-1:0] er;
    mptw_transaction_t front;
    bus.req_valid_i  = v;
    bus.mptw_ready_i = rdy;
    flush            = fl;
    @(negedge clk);
    load = (!m_valid || rdy) && !fl;
    w    = pick(v);
    er   = '0;
    if (load && w >= 0) er[w] = 1'b1;
    obs_ready = bus.req_ready_o;
    chk("req_ready", 64'(obs_ready), 64'(er));
    chk("onehot", 64'($countones(obs_ready) <= 1), 64'd1);
    chk("valid", 64'(bus.mptw_valid_o), 64'(m_valid));
    chk("busy", 64'(busy), 64'(m_valid || (|v)));
    if (m_valid) begin
      chk("txn", 64'(bus.mptw_transaction_o), 64'(m_txn));
      chk("grant_id", 64'(bus.grant_id_o), 64'(m_id));
    end
    if (m_valid && rdy && !fl) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        front = sb.pop_front();
        chk("deliver", 64'(bus.mptw_transaction_o), 64'(front));
      end
    end
    for (int k = 0; k < N; k++) if (!v[k]) wait_cnt[k] = 0;
    if (fl) begin
      sb.delete();
      m_valid = 1'b0;
    end else if (load && w >= 0) begin
      for (int k = 0; k < N; k++) begin
        if (k == w) begin
          chk("starve", 64'(wait_cnt[k] <= N - 1), 64'd1);
          wait_cnt[k] = 0;
        end else if (v[k]) begin
          wait_cnt[k]++;
        end
      end
      m_valid = 1'b1;
      m_txn   = bus.req_transaction_i[w];
      m_id    = w;
      m_last  = w;
      sb.push_back(m_txn);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  mptw_transaction_t txn_a;

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    bus.req_valid_i  = '1;
    bus.mptw_ready_i = 1'b1;
    for (int k = 0; k < N; k++) bus.req_transaction_i[k] = rand_txn();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.mptw_valid_o), 64'd0);
    chk("rst_txn", 64'(bus.mptw_transaction_o), 64'd0);
    chk("rst_id", 64'(bus.grant_id_o), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    bus.req_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All requesters valid: strict rotation from requester 0.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      chk("rr_seq_id", 64'(bus.grant_id_o), 64'(i % 4));
      chk("rr_seq_valid", 64'(bus.mptw_valid_o), 64'd1);
    end
    cycle(4'b0000, 1'b1, 1'b0);

    // Single requester under stall.
    txn_a = 42'h2_1234_5678_9A;
    bus.req_transaction_i[2] = txn_a;
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      chk("stall_ready", 64'(obs_ready), (i == 0) ? 64'h4 : 64'h0);
      chk("stall_txn", 64'(bus.mptw_transaction_o), 64'(txn_a));
      chk("stall_id", 64'(bus.grant_id_o), 64'd2);
    end
    cycle(4'b0000, 1'b1, 1'b0);
    chk("stall_drop", 64'(bus.mptw_valid_o), 64'd0);

    // Wrap-around priority from last_grant = 3.
    cycle(4'b1000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0);
    chk("wrap_first", 64'(bus.grant_id_o), 64'd0);
    cycle(4'b1001, 1'b1, 1'b0);
    chk("wrap_second", 64'(bus.grant_id_o), 64'd3);
    cycle(4'b0000, 1'b1, 1'b0);

    // Flush over a held transaction.
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b1);
    chk("flush_ready", 64'(obs_ready), 64'd0);
    chk("flush_valid", 64'(bus.mptw_valid_o), 64'd0);
    cycle(4'b0010, 1'b1, 1'b0);
    chk("post_flush_ready", 64'(obs_ready), 64'h2);
    chk("post_flush_id", 64'(bus.grant_id_o), 64'd1);

    // Asynchronous reset between edges while holding a transaction.
    cycle(4'b1111, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.mptw_valid_o), 64'd0);
    chk("arst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_txn", 64'(bus.mptw_transaction_o), 64'd0);
    bus.req_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(4'b1111, 1'b1, 1'b0);
    chk("arst_first_grant", 64'(bus.grant_id_o), 64'd0);

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) begin
        v[k] = ($urandom_range(0, 9) < 6);
        bus.req_transaction_i[k] = rand_txn();
      end
      cycle(v, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    cycle(4'b0000, 1'b1, 1'b0);
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
